pwm_audio_capture: RTL and testbench

PWM audio demodulator: the receive end of the 8-channel PWM audio outputs. It samples one PWM pin driven by a PWM audio generator (256-clock frame, pin high for `sample` clocks starting at each frame edge). Per frame it recovers the 8-bit PCM sample and presents it on a valid/ready stream. It is used for on-chip loopback checking of the bytebeat channels and as an audio input path from an external PWM source.

---
 rtl/pwm_audio_capture.sv | 156 +++++++++++++++
 tb/tb_pwm_audio_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_capture.sv
// PWM audio demodulator: measures the high time of each edge-delimited PWM frame
// and delivers the recovered 8-bit PCM sample on a one-entry valid/ready register.
module pwm_audio_capture #(
  parameter int PERIOD      = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] sample_out,
  output logic       sample_vld,
  input  logic       sample_rdy,
  output logic       locked,
  output logic       overrun
);

  localparam int CNT_W = $clog2(PERIOD) + 2;
  localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_WHEEL   = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pwm_dly_q, pwm_dly_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   locked_q, locked_d;
  logic [7:0]             out_q, out_d;
  logic                   vld_q, vld_d;
  logic                   ovr_q, ovr_d;

  logic                   pwm_s;
  logic                   rise;
  logic                   emit;
  logic [7:0]             emit_val;
  logic [CNT_W-1:0]       period_inc;
  logic [CNT_W-1:0]       high_inc;
  logic [CNT_W+7:0]       high_ext;
  logic [7:0]             high_sat;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_dly_q;

  // Widen before clamping so small PERIOD values still compare against 255 correctly.
  assign high_ext = {8'd0, high_q};
  assign high_sat = (high_ext > (CNT_W+8)'(255)) ? 8'hFF : high_ext[7:0];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pwm_in};
    pwm_dly_d  = pwm_s;
    period_inc = (period_q == CNT_MAX) ? period_q : period_q + CNT_ONE;
    high_inc   = (pwm_s && (high_q != CNT_MAX)) ? high_q + CNT_ONE : high_q;
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    locked_d = locked_q;
    emit     = 1'b0;
    emit_val = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d  = ST_MEASURE;
          period_d = CNT_ONE;
          high_d   = CNT_ONE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          if (period_q == CNT_PERIOD) begin
            emit     = 1'b1;
            emit_val = high_sat;
            locked_d = 1'b1;
          end else begin
            locked_d = 1'b0;
          end
          period_d = CNT_ONE;
          high_d   = CNT_ONE;
        end else if (period_q == CNT_PERIOD) begin
          // Frame ran its full length without a new edge: the line has gone static.
          state_d  = ST_WHEEL;
          emit     = 1'b1;
          emit_val = high_sat;
          locked_d = 1'b0;
          period_d = CNT_ONE;
        end else begin
          period_d = period_inc;
          high_d   = high_inc;
        end
      end
      ST_WHEEL: begin
        if (rise) begin
          state_d  = ST_MEASURE;
          period_d = CNT_ONE;
          high_d   = CNT_ONE;
        end else if (period_q == CNT_PERIOD) begin
          emit     = 1'b1;
          emit_val = pwm_s ? 8'hFF : 8'h00;
          period_d = CNT_ONE;
        end else begin
          period_d = period_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    if (emit) begin
      out_d = emit_val;
      vld_d = 1'b1;
      if (vld_q && !sample_rdy) ovr_d = 1'b1;
    end else if (vld_q && sample_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      pwm_dly_q <= 1'b0;
      state_q   <= ST_IDLE;
      period_q  <= '0;
      high_q    <= '0;
      locked_q  <= 1'b0;
      out_q     <= 8'h00;
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pwm_dly_q <= pwm_dly_d;
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      locked_q  <= locked_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sample_out = out_q;
  assign sample_vld = vld_q;
  assign locked     = locked_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_audio_capture.sv
// Bench for pwm_audio_capture: builds PWM waveforms, derives expected outputs from
// the edge-interval rules, then replays the waveform and compares every cycle.
module tb_pwm_audio_capture;

  localparam int PER  = 256;
  localparam int SS   = 2;
  localparam int MAXN = 6000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic       sample_rdy = 1'b0;
  logic [7:0] sample_out;
  logic       sample_vld;
  logic       locked;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus and expectation tables for one scenario
  int   n_len;
  bit   pin_a [MAXN];
  bit   rdy_a [MAXN];
  bit   em_a  [MAXN];
  int   emv_a [MAXN];
  int   lk_ev [MAXN];
  bit   e_vld [MAXN];
  int   e_out [MAXN];
  bit   e_lk  [MAXN];
  bit   e_ovr [MAXN];
  int   em_q[$];

  always #5 clk = ~clk;

  pwm_audio_capture #(.PERIOD(PER), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .sample_out (sample_out),
    .sample_vld (sample_vld),
    .sample_rdy (sample_rdy),
    .locked     (locked),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    n_len = 0;
  endtask

  task automatic add_level(input int len, input bit v);
    for (int i = 0; i < len; i++) begin
      pin_a[n_len] = v;
      n_len++;
    end
  endtask

  // One generator frame: high for the first hi clocks, low for the rest
  task automatic add_frame(input int len, input int hi);
    for (int i = 0; i < len; i++) begin
      pin_a[n_len] = (i < hi);
      n_len++;
    end
  endtask

  task automatic add_tail(input int hi);
    add_frame(PER, hi);
    add_level(12, 1'b0);
  endtask

  // Line value the design sees after the synchronizer, indexed by clock edge
  function automatic bit s_at(input int m);
    return (m >= SS) ? pin_a[m-SS] : 1'b0;
  endfunction

  task automatic add_emit(input int c, input int v, input int lk);
    em_a[c]  = 1'b1;
    emv_a[c] = v;
    lk_ev[c] = lk;
    em_q.push_back(c);
  endtask

  // Walk the rising edges and decide, per edge-to-edge interval, what is emitted and when
  task automatic compute_emits();
    int rises[$];
    int a, b, len, hi;
    em_q.delete();
    for (int m = 0; m < n_len; m++) begin
      em_a[m]  = 1'b0;
      emv_a[m] = 0;
      lk_ev[m] = -1;
      rdy_a[m] = 1'b0;
    end
    for (int m = 0; m < n_len; m++)
      if (s_at(m) && !((m > 0) && s_at(m-1))) rises.push_back(m);
    for (int i = 0; i < rises.size(); i++) begin
      a   = rises[i];
      b   = (i + 1 < rises.size()) ? rises[i+1] : n_len;
      len = b - a;
      hi  = 0;
      for (int k = 0; k < len && k < PER; k++) hi += int'(s_at(a + k));
      if (hi > 255) hi = 255;
      if (b < n_len && len == PER) begin
        add_emit(b, hi, 1);
      end else if (b < n_len && len < PER) begin
        lk_ev[b] = 0;
      end else if (len > PER) begin
        add_emit(a + PER, hi, 0);
        for (int t = a + 2*PER; t < b; t += PER)
          add_emit(t, s_at(t) ? 255 : 0, 0);
      end
    end
  endtask

  // One-entry output register behaviour applied to the emit schedule and ready pattern
  task automatic compute_outputs();
    bit v, lk, ov;
    int o;
    v = 0; lk = 0; ov = 0; o = 0;
    for (int m = 0; m < n_len; m++) begin
      if (lk_ev[m] >= 0) lk = (lk_ev[m] == 1);
      if (em_a[m]) begin
        if (v && !rdy_a[m]) ov = 1;
        o = emv_a[m];
        v = 1;
      end else if (v && rdy_a[m]) begin
        v = 0;
      end
      e_vld[m] = v; e_out[m] = o; e_lk[m] = lk; e_ovr[m] = ov;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " sample_out"}, int'(sample_out), 0);
    check({tag, " sample_vld"}, int'(sample_vld), 0);
    check({tag, " locked"},     int'(locked),     0);
    check({tag, " overrun"},    int'(overrun),    0);
  endtask

  task automatic run(input string name, input int abort_at);
    rst_n = 1'b0; pwm_in = 1'b0; sample_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero({name, " reset"});
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < n_len; n++) begin
      if (n > 0) @(negedge clk);
      pwm_in     = pin_a[n];
      sample_rdy = rdy_a[n];
      @(posedge clk);
      #1;
      check($sformatf("%s c%0d vld", name, n),  int'(sample_vld), int'(e_vld[n]));
      check($sformatf("%s c%0d out", name, n),  int'(sample_out), e_out[n]);
      check($sformatf("%s c%0d lock", name, n), int'(locked),     int'(e_lk[n]));
      check($sformatf("%s c%0d ovr", name, n),  int'(overrun),    int'(e_ovr[n]));
      if (em_a[n])
        $display("[TB] %s cycle %0d emit 0x%02h locked %0d rdy %0d",
                 name, n, emv_a[n], e_lk[n], rdy_a[n]);
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_zero({name, " async"});
        break;
      end
    end
  endtask

  initial begin
    int len, hi, r;

    // Lock onto a constant 0x80 after a quiet idle line
    clear_stim(); add_level(300, 1'b0);
    repeat (4) add_frame(PER, 8'h80);
    add_tail(8'h80);
    compute_emits();
    for (int m = 0; m < n_len; m++) rdy_a[m] = 1'b1;
    compute_outputs(); run("lock", -1);

    // Extremes: full scale, silent line through the wheel, then back to 0x10
    clear_stim();
    repeat (3) add_frame(PER, 255);
    repeat (3) add_frame(PER, 0);
    repeat (3) add_frame(PER, 8'h10);
    add_tail(8'h10);
    compute_emits();
    for (int m = 0; m < n_len; m++) rdy_a[m] = 1'($urandom_range(0, 1));
    compute_outputs(); run("extreme", -1);

    // Backpressure across two emits, then one transfer
    clear_stim(); add_frame(PER, 8'h20); add_frame(PER, 8'h30);
    add_frame(PER, 8'h50); add_frame(PER, 8'h60); add_tail(8'h70);
    compute_emits();
    if (em_q.size() >= 2) rdy_a[em_q[1] + 10] = 1'b1;
    compute_outputs(); run("bp_ovr", -1);

    // Ready raised exactly on the emit that replaces a waiting sample
    clear_stim(); add_frame(PER, 8'h20); add_frame(PER, 8'h30);
    add_frame(PER, 8'h50); add_tail(8'h60);
    compute_emits();
    if (em_q.size() >= 2) rdy_a[em_q[1]] = 1'b1;
    compute_outputs(); run("bp_edge", -1);

    // Short frames are dropped, then 0x40 frames relock
    clear_stim(); repeat (2) add_frame(PER, 8'h40);
    repeat (3) add_frame(200, 8'h40);
    repeat (3) add_frame(PER, 8'h40);
    add_tail(8'h40);
    compute_emits();
    for (int m = 0; m < n_len; m++) rdy_a[m] = 1'b1;
    compute_outputs(); run("badlen", -1);

    // Random frame lengths, samples and ready pattern
    clear_stim(); add_level(37, 1'b0);
    for (int f = 0; f < 12; f++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400)) : PER;
      r   = int'($urandom_range(0, 5));
      hi  = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(1, 254));
      if (hi > len) hi = len;
      add_frame(len, hi);
    end
    add_tail(int'($urandom_range(1, 254)));
    compute_emits();
    for (int m = 0; m < n_len; m++) rdy_a[m] = 1'($urandom_range(0, 1));
    compute_outputs(); run("random", -1);

    // Build up an overrun, then reset asynchronously 100 clocks into a frame
    clear_stim(); repeat (5) add_frame(PER, 8'h20);
    compute_emits();
    compute_outputs();
    run("async", (em_q.size() >= 3) ? em_q[2] + 100 : n_len - 1);

    // Restart mid-frame: the partial frame is dropped, the next full frame emits
    clear_stim(); add_level(28, 1'b1); add_level(128, 1'b0);
    repeat (3) add_frame(PER, 8'h80);
    add_tail(8'h80);
    compute_emits();
    for (int m = 0; m < n_len; m++) rdy_a[m] = 1'b1;
    compute_outputs(); run("resync", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
